issue_exec_shift_queue: RTL and testbench
=========================================

// Module: issue_exec_shift_queue
// PURPOSE
// - Parametrised shift execution unit between a reservation station (RS) and the execute-decision/writeback unit.
// - Successor to the single-entry shift issue stage. Adds:
//   - DEPTH-entry operand queue
//   - arithmetic and 32-bit word shifts
//   - flush and occupancy report
//   - optional flag generation
// - Head entry is shifted combinationally and held on the outputs until the consumer accepts it with canGo_i.
// PARAMETERS
// - XLEN       64   data width; power of 2, >= 32
// - ROBsize    16   ROB entries
// - TAG_W      $clog2(ROBsize+1)   tag width
// - CMD_W      10   command field width
// - DEPTH      2    queue entries; power of 2, >= 1
// - LEFT_BIT   7    command bit: 1 = left shift
// - ARITH_BIT  8    command bit: 1 = arithmetic right shift
// - WORD_BIT   9    command bit: 1 = 32-bit word op
// PORTS
// - clk_i                        in   1               clock
// - reset_i                      in   1               synchronous, active-high reset
// - flush_i                      in   1               discard every queued entry
// - readyRS_i                    in   1               RS presents a valid operation
// - reservationStationVal1_i     in   XLEN            value to shift
// - reservationStationVal2_i     in   XLEN            shift amount source
// - reservationStationCommands_i in   CMD_W           decoded command
// - reservationStationTag_i      in   TAG_W           ROB tag
// - stallRS_o                    out  1               queue cannot accept this cycle
// - canGo_i                      in   1               consumer accepts the head entry
// - valid_o                      out  1               head entry valid
// - executeVal_o                 out  XLEN            shift result
// - executeCommands_o            out  CMD_W           head command
// - executeTag_o                 out  TAG_W           head tag
// - executeFlags_o               out  4               {N,Z,C,V}
// - occupancy_o                  out  $clog2(DEPTH+1) number of queued entries
// BEHAVIOUR
// - Reset: count, head and tail pointers = 0; all storage = 0.
//   - Output reset values: valid_o=0, stallRS_o=0, occupancy_o=0, executeVal_o/Tag/Commands/Flags = 0.
// - Push: readyRS_i & ~stallRS_o writes the RS fields at the tail. Pop: valid_o & canGo_i advances the head.
// - stallRS_o = (count==DEPTH) & ~(valid_o & canGo_i).
//   - Combinational path canGo_i -> stallRS_o is intended.
//   - A full queue accepts a push in the same cycle it pops.
// - valid_o = (count != 0). Latency: push at cycle N into an empty queue -> valid_o=1 at cycle N+1.
// - Outputs are a combinational function of the head entry.
//   - They hold stable while valid_o & ~canGo_i.
//   - When count==0 they show the last-popped entry with valid_o=0; the consumer ignores them.
// - Order is strict FIFO. Pointers wrap modulo DEPTH. Push+pop in one cycle leaves count unchanged.
// - canGo_i while empty: no effect. readyRS_i while stalled: not accepted; the RS retains the operation.
// - flush_i has priority over push and pop: next cycle count=0, pointers=0, valid_o=0.
//   - A push presented in the flush cycle is dropped. stallRS_o is not affected by flush_i in that cycle.
// - reset_i mid-operation: same result as a flush, plus storage cleared to 0.
// - Shift rules:
//   - XLEN mode (WORD_BIT=0): shamt = Val2[$clog2(XLEN)-1:0].
//     - LEFT_BIT=1: logical left. ARITH_BIT is ignored.
//     - LEFT_BIT=0: right shift; sign-fill if ARITH_BIT=1, else zero-fill.
//   - Word mode (WORD_BIT=1): shamt = Val2[4:0]; the shift operates on Val1[31:0].
//     - The 32-bit result is sign-extended from bit 31 to XLEN (SLLW/SRLW/SRAW semantics).
//   - shamt = 0 returns Val1 unchanged (word mode: sign-extended low word).
// CONFIGURATION
// - SHIFT_FLAGS_EN defined:
//   - N = result MSB; Z = (result == 0).
//   - C = last bit shifted out: 0 when shamt=0; word mode uses bit 31/bit 0 of the low word.
//   - V = 0.
// - SHIFT_FLAGS_EN undefined: executeFlags_o tied to 4'b0000; no flag logic is synthesised.
// TESTING
// - Reset, then idle: valid_o=0, stallRS_o=0, occupancy_o=0, executeVal_o=0.
// - Push Val1=64'h1, Val2=4, LEFT=1, tag=3, canGo_i=1 -> next cycle valid_o=1, executeVal_o=64'h10, executeTag_o=3; empty the cycle after.
// - Push Val1=64'h8000_0000_0000_0000, shamt 63, ARITH=1 -> 64'hFFFF_FFFF_FFFF_FFFF.
//   - Same with ARITH=0 -> 64'h1.
// - Word op: Val1=64'h0000_0000_4000_0000, shamt 1, LEFT=1, WORD=1 -> 64'hFFFF_FFFF_8000_0000.
// - DEPTH=2, canGo_i=0, push tags 1,2 -> stallRS_o=1, occupancy_o=2.
//   - Then canGo_i=1 with push tag 3 the same cycle -> accepted; pops yield tags 1,2,3 in order.
// - Two entries queued, flush_i=1 together with readyRS_i=1 -> next cycle valid_o=0, occupancy_o=0, pushed entry never appears.
//   - With SHIFT_FLAGS_EN: Val1=64'h3, shamt 1, right logical -> flags {N,Z,C,V}=4'b0010.

Source files
------------

// File: rtl/issue_exec_shift_queue.sv
// issue_exec_shift_queue: DEPTH-entry FIFO of RS shift ops; head shifted combinationally; optional flags under SHIFT_FLAGS_EN
module issue_exec_shift_queue #(
  parameter int XLEN      = 64,
  parameter int ROBsize   = 16,
  parameter int TAG_W     = $clog2(ROBsize + 1),
  parameter int CMD_W     = 10,
  parameter int DEPTH     = 2,
  parameter int LEFT_BIT  = 7,
  parameter int ARITH_BIT = 8,
  parameter int WORD_BIT  = 9
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       readyRS_i,
  input  logic [XLEN-1:0]            reservationStationVal1_i,
  input  logic [XLEN-1:0]            reservationStationVal2_i,
  input  logic [CMD_W-1:0]           reservationStationCommands_i,
  input  logic [TAG_W-1:0]           reservationStationTag_i,
  output logic                       stallRS_o,
  input  logic                       canGo_i,
  output logic                       valid_o,
  output logic [XLEN-1:0]            executeVal_o,
  output logic [CMD_W-1:0]           executeCommands_o,
  output logic [TAG_W-1:0]           executeTag_o,
  output logic [3:0]                 executeFlags_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [XLEN-1:0]  r_val1  [DEPTH];
  logic [SW-1:0]    r_shamt [DEPTH];
  logic [CMD_W-1:0] r_cmd   [DEPTH];
  logic [TAG_W-1:0] r_tag   [DEPTH];
  logic [PW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_count;
  logic             w_pop, w_push, w_full;
  logic [PW-1:0]    w_head_nxt, w_tail_nxt, w_out;
  logic [XLEN-1:0]  w_a, w_sll, w_srl, w_sra, w_res;
  logic [SW-1:0]    w_sh;
  logic [CMD_W-1:0] w_c;
  logic [31:0]      w_lo, w_sllw, w_srlw, w_sraw, w_word_res;
  logic [4:0]       w_sh5;
  logic             w_left, w_arith, w_word;
  logic             w_unused_val2;
  assign w_unused_val2 = ^reservationStationVal2_i[XLEN-1:SW];
  assign w_full     = r_count == CW'(DEPTH);
  assign w_pop      = (r_count != '0) & canGo_i;
  assign w_push     = readyRS_i & ~stallRS_o;
  assign stallRS_o  = w_full & ~w_pop;
  assign valid_o    = r_count != '0;
  assign occupancy_o = r_count;
  assign w_head_nxt = (r_head == PW'(DEPTH - 1)) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
  // when empty, the slot just behind the head still holds the last-popped entry
  assign w_out      = (r_count != '0) ? r_head : (r_head == '0) ? PW'(DEPTH - 1) : r_head - 1'b1;
  assign w_a        = r_val1[w_out];
  assign w_sh       = r_shamt[w_out];
  assign w_c        = r_cmd[w_out];
  assign w_left     = w_c[LEFT_BIT];
  assign w_arith    = w_c[ARITH_BIT];
  assign w_word     = w_c[WORD_BIT];
  assign w_lo       = w_a[31:0];
  assign w_sh5      = w_sh[4:0];
  assign w_sll      = w_a << w_sh;
  assign w_srl      = w_a >> w_sh;
  assign w_sra      = $signed(w_a) >>> w_sh;
  assign w_sllw     = w_lo << w_sh5;
  assign w_srlw     = w_lo >> w_sh5;
  assign w_sraw     = $signed(w_lo) >>> w_sh5;
  assign w_word_res = w_left ? w_sllw : w_arith ? w_sraw : w_srlw;
  assign w_res      = w_word ? XLEN'($signed(w_word_res)) : w_left ? w_sll : w_arith ? w_sra : w_srl;
  assign executeVal_o      = w_res;
  assign executeCommands_o = w_c;
  assign executeTag_o      = r_tag[w_out];
`ifdef SHIFT_FLAGS_EN
  logic [XLEN-1:0] w_mx;
  logic [31:0]     w_mw;
  logic            w_carry;
  // one-hot mask on the last bit shifted out; a zero shift pushes the bit off the mask
  assign w_mx    = w_left ? XLEN'(1) << (XLEN - 32'(w_sh)) : XLEN'(1) << (32'(w_sh) - 32'd1);
  assign w_mw    = w_left ? 32'd1 << (32'd32 - 32'(w_sh5)) : 32'd1 << (32'(w_sh5) - 32'd1);
  assign w_carry = w_word ? |(w_lo & w_mw) : |(w_a & w_mx);
  assign executeFlags_o = {w_res[XLEN-1], w_res == '0, w_carry, 1'b0};
`else
  assign executeFlags_o = 4'b0000;
`endif
  // queue storage and pointers; flush drops everything including a same-cycle push
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_val1[i]  <= '0;
        r_shamt[i] <= '0;
        r_cmd[i]   <= '0;
        r_tag[i]   <= '0;
      end
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_val1[r_tail]  <= reservationStationVal1_i;
        r_shamt[r_tail] <= reservationStationVal2_i[SW-1:0];
        r_cmd[r_tail]   <= reservationStationCommands_i;
        r_tag[r_tail]   <= reservationStationTag_i;
        r_tail          <= w_tail_nxt;
      end
      if (w_pop) r_head <= w_head_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_issue_exec_shift_queue.sv
// tb_issue_exec_shift_queue: directed and randomized checks of the shift queue against a queue-based model
module tb_issue_exec_shift_queue;
  logic        clk = 0, reset_i = 1, flush_i = 0, readyRS_i = 0, canGo_i = 0;
  logic [63:0] v1 = 0, v2 = 0;
  logic [9:0]  cmd = 0;
  logic [4:0]  tag = 0;
  logic        stallRS_o, valid_o;
  logic [63:0] executeVal_o;
  logic [9:0]  executeCommands_o;
  logic [4:0]  executeTag_o;
  logic [3:0]  executeFlags_o;
  logic [1:0]  occupancy_o;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [63:0] v; logic [9:0] c; logic [4:0] t; logic [3:0] f;} ent_t;
  ent_t q[$];

  issue_exec_shift_queue dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i), .readyRS_i(readyRS_i),
    .reservationStationVal1_i(v1), .reservationStationVal2_i(v2),
    .reservationStationCommands_i(cmd), .reservationStationTag_i(tag),
    .stallRS_o(stallRS_o), .canGo_i(canGo_i), .valid_o(valid_o),
    .executeVal_o(executeVal_o), .executeCommands_o(executeCommands_o),
    .executeTag_o(executeTag_o), .executeFlags_o(executeFlags_o), .occupancy_o(occupancy_o));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_shift(logic [63:0] a, logic [63:0] b, logic [9:0] c);
    int sh;
    logic [31:0] lo;
    logic [63:0] ones;
    ones = '1;
    if (c[9]) begin
      sh = int'(b[4:0]);
      lo = a[31:0];
      if (c[7]) lo = lo << sh;
      else if (c[8] && a[31]) lo = (lo >> sh) | ~(ones[31:0] >> sh);
      else lo = lo >> sh;
      return {{32{lo[31]}}, lo};
    end
    sh = int'(b[5:0]);
    if (c[7]) return a << sh;
    if (c[8] && a[63]) return (a >> sh) | ~(ones >> sh);
    return a >> sh;
  endfunction

  function automatic logic [3:0] ref_flags(logic [63:0] a, logic [63:0] b, logic [9:0] c);
`ifdef SHIFT_FLAGS_EN
    logic [63:0] r;
    int sh, w;
    logic cy;
    r  = ref_shift(a, b, c);
    w  = c[9] ? 32 : 64;
    sh = c[9] ? int'(b[4:0]) : int'(b[5:0]);
    cy = (sh == 0) ? 1'b0 : c[7] ? a[w - sh] : a[sh - 1];
    return {r[63], r == 64'h0, cy, 1'b0};
`else
    return 4'b0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1;
    tick();
    tick();
    reset_i = 0;
    #1;
    n_tests += 5;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    if (stallRS_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stallRS_o); end
    if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d expected 0", occupancy_o); end
    if (executeVal_o !== 64'h0) begin n_fail++; $display("FAIL reset_val: got %h expected 0", executeVal_o); end
    if ({executeTag_o, executeCommands_o, executeFlags_o} !== 19'h0) begin
      n_fail++; $display("FAIL reset_fields: got tag %h cmd %h flags %h expected 0", executeTag_o, executeCommands_o, executeFlags_o);
    end
  endtask

  task automatic test_basic();
    canGo_i = 1; readyRS_i = 1; v1 = 64'h1; v2 = 64'd4; cmd = 10'h080; tag = 5'd3;
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b expected 0", valid_o); end
    tick();
    readyRS_i = 0;
    #1;
    n_tests += 3;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", valid_o); end
    if (executeVal_o !== 64'h10) begin n_fail++; $display("FAIL basic_val: got %h expected 10", executeVal_o); end
    if (executeTag_o !== 5'd3) begin n_fail++; $display("FAIL basic_tag: got %0d expected 3", executeTag_o); end
    tick();
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b expected 0", valid_o); end
  endtask

  task automatic test_shifts();
    logic [63:0] tv1 [4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_8000_00F0};
    logic [63:0] tv2 [4] = '{64'd63, 64'd63, 64'd1, 64'd4};
    logic [9:0]  tc  [4] = '{10'h100, 10'h000, 10'h280, 10'h300};
    logic [63:0] tex [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_F800_000F};
    canGo_i = 1;
    for (int i = 0; i < 4; i++) begin
      readyRS_i = 1; v1 = tv1[i]; v2 = tv2[i]; cmd = tc[i]; tag = 5'(i + 7);
      tick();
      readyRS_i = 0;
      #1;
      n_tests++;
      if (executeVal_o !== tex[i] || valid_o !== 1'b1) begin
        n_fail++; $display("FAIL shift_%0d: got %h valid %b expected %h valid 1", i, executeVal_o, valid_o, tex[i]);
      end
      tick();
    end
  endtask

  task automatic test_full_push_pop();
    logic [4:0] want [3] = '{5'd1, 5'd2, 5'd3};
    canGo_i = 0; readyRS_i = 1; v1 = 64'h5; v2 = 0; cmd = 0; tag = 5'd1;
    tick();
    tag = 5'd2;
    tick();
    readyRS_i = 0;
    #1;
    n_tests += 2;
    if (stallRS_o !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b expected 1", stallRS_o); end
    if (occupancy_o !== 2'd2) begin n_fail++; $display("FAIL full_occ: got %0d expected 2", occupancy_o); end
    canGo_i = 1; readyRS_i = 1; tag = 5'd3;
    #1;
    n_tests++;
    if (stallRS_o !== 1'b0) begin n_fail++; $display("FAIL full_pop_stall: got %b expected 0", stallRS_o); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (executeTag_o !== want[i] || valid_o !== 1'b1) begin
        n_fail++; $display("FAIL order_%0d: got tag %0d valid %b expected %0d", i, executeTag_o, valid_o, want[i]);
      end
      tick();
      readyRS_i = 0;
      #1;
    end
    n_tests++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %b expected 0", valid_o); end
  endtask

  task automatic test_flush();
    canGo_i = 0; readyRS_i = 1; v1 = 64'h9; v2 = 0; cmd = 0; tag = 5'd4;
    tick();
    tag = 5'd5;
    tick();
    canGo_i = 1; flush_i = 1; tag = 5'd9;
    #1;
    n_tests++;
    if (stallRS_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", stallRS_o); end
    tick();
    flush_i = 0; readyRS_i = 0;
    #1;
    n_tests += 2;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", valid_o); end
    if (occupancy_o !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occupancy_o); end
    tick();
    n_tests++;
    if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      n_fail++; $display("FAIL flush_drop: got valid %b occ %0d expected 0 0", valid_o, occupancy_o);
    end
  endtask

  task automatic test_flags();
    logic [3:0] want;
`ifdef SHIFT_FLAGS_EN
    want = 4'b0010;
`else
    want = 4'b0000;
`endif
    canGo_i = 1; readyRS_i = 1; v1 = 64'h3; v2 = 64'd1; cmd = 10'h000; tag = 5'd6;
    tick();
    readyRS_i = 0;
    #1;
    n_tests++;
    if (executeFlags_o !== want) begin n_fail++; $display("FAIL flags: got %b expected %b", executeFlags_o, want); end
    tick();
  endtask

  task automatic test_reset_mid();
    canGo_i = 0; readyRS_i = 1; v1 = 64'hDEAD_BEEF; v2 = 64'd3; cmd = 10'h3FF; tag = 5'd17;
    tick();
    tick();
    readyRS_i = 0; reset_i = 1;
    tick();
    reset_i = 0;
    #1;
    n_tests += 2;
    if (valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
      n_fail++; $display("FAIL midreset_state: got valid %b occ %0d expected 0 0", valid_o, occupancy_o);
    end
    if ({executeVal_o, executeTag_o, executeCommands_o} !== 79'h0) begin
      n_fail++; $display("FAIL midreset_fields: got val %h tag %h cmd %h expected 0", executeVal_o, executeTag_o, executeCommands_o);
    end
  endtask

  task automatic test_random();
    bit pop, stall, push;
    q.delete();
    for (int k = 0; k < 600; k++) begin
      readyRS_i = $urandom_range(0, 3) != 0;
      canGo_i   = $urandom_range(0, 2) != 0;
      flush_i   = $urandom_range(0, 24) == 0;
      v1  = {$urandom, $urandom};
      v2  = {$urandom, $urandom};
      cmd = 10'($urandom_range(0, 1023));
      tag = 5'($urandom_range(0, 31));
      @(negedge clk);
      pop   = q.size() != 0 && canGo_i;
      stall = q.size() == 2 && !pop;
      push  = readyRS_i && !stall;
      n_tests += 3;
      if (valid_o !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", k, valid_o, q.size() != 0); end
      if (stallRS_o !== stall) begin n_fail++; $display("FAIL rnd_stall@%0d: got %b expected %b", k, stallRS_o, stall); end
      if (occupancy_o !== 2'(q.size())) begin n_fail++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", k, occupancy_o, q.size()); end
      if (q.size() != 0) begin
        n_tests++;
        if (executeVal_o !== q[0].v || executeTag_o !== q[0].t || executeCommands_o !== q[0].c || executeFlags_o !== q[0].f) begin
          n_fail++;
          $display("FAIL rnd_head@%0d: got val %h tag %h cmd %h flags %b expected val %h tag %h cmd %h flags %b",
                   k, executeVal_o, executeTag_o, executeCommands_o, executeFlags_o, q[0].v, q[0].t, q[0].c, q[0].f);
        end
      end
      @(posedge clk);
      if (flush_i) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{ref_shift(v1, v2, cmd), cmd, tag, ref_flags(v1, v2, cmd)});
      end
      #1;
    end
    flush_i = 0; readyRS_i = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shifts();
    test_full_push_pop();
    test_flush();
    test_flags();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
